sync_fifo_flags: RTL and testbench

//  Parametrised single-clock FIFO; successor to the basic 16x8 sync FIFO.

---
 rtl/sync_fifo_flags_pkg.sv | 15 +
 rtl/sync_fifo_flags_mem.sv | 26 ++
 rtl/sync_fifo_flags.sv | 98 +++++++++
 tb/tb_sync_fifo_flags.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_flags_pkg.sv
// Shared defaults for the flagged synchronous FIFO.
// The benches read the same constants so geometry and thresholds stay in one place.
package sync_fifo_flags_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AF_THRESH = 14;
    localparam int DEF_AE_THRESH = 2;

    // Bits needed to index DEPTH entries; pointers and the count add one more.
    function automatic int index_bits(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_flags_mem.sv
// Storage array for sync_fifo_flags: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module sync_fifo_flags_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk_i,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags,
// error pulses and a standard or first-word-fall-through read port.
module sync_fifo_flags
    import sync_fifo_flags_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int PTR_WIDTH = index_bits(DEPTH),
    parameter int AF_THRESH = DEF_AF_THRESH,
    parameter int AE_THRESH = DEF_AE_THRESH,
    parameter bit FWFT      = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 wr_en_i,
    output logic                 wr_error_o,
    output logic                 full_o,
    output logic                 almost_full_o,
    output logic [WIDTH-1:0]     rdata_o,
    input  logic                 rd_en_i,
    output logic                 rd_error_o,
    output logic                 empty_o,
    output logic                 almost_empty_o,
    output logic                 rvalid_o,
    output logic [PTR_WIDTH:0]   count_o
);

    localparam int CNT_W = PTR_WIDTH + 1;

    logic [PTR_WIDTH:0] wr_ptr;
    logic [PTR_WIDTH:0] rd_ptr;
    logic [PTR_WIDTH:0] count;
    logic               rd_ok;
    logic               wr_ok;
    logic [WIDTH-1:0]   mem_rdata;
    logic [WIDTH-1:0]   rdata_q;
    logic               rvalid_q;
    logic               wr_error_q;
    logic               rd_error_q;

    // With one wrap bit the pointer difference is the occupancy 0..DEPTH,
    // so count always tracks the registered pointers exactly.
    assign count = wr_ptr - rd_ptr;

    assign empty_o        = (count == '0);
    assign full_o         = (count == CNT_W'(DEPTH));
    assign almost_full_o  = (count >= CNT_W'(AF_THRESH));
    assign almost_empty_o = (count <= CNT_W'(AE_THRESH));
    assign count_o        = count;

    // A read frees a slot in the same edge, so a full FIFO still accepts a write.
    assign rd_ok = rd_en_i & ~empty_o;
    assign wr_ok = wr_en_i & (~full_o | rd_ok);

    sync_fifo_flags_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_WIDTH)
    ) u_mem (
        .clk_i (clk_i),
        .we    (wr_ok),
        .waddr (wr_ptr[PTR_WIDTH-1:0]),
        .wdata (wdata_i),
        .raddr (rd_ptr[PTR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            wr_error_q <= 1'b0;
            rd_error_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + CNT_W'(1);
            end
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + CNT_W'(1);
                rdata_q <= mem_rdata;
            end
            rvalid_q   <= rd_ok;
            wr_error_q <= wr_en_i & full_o & ~rd_ok;
            rd_error_q <= rd_en_i & empty_o;
        end
    end

    assign wr_error_o = wr_error_q;
    assign rd_error_o = rd_error_q;

    // FWFT shows the head entry directly; standard mode presents the registered pop.
    assign rdata_o  = FWFT ? mem_rdata : rdata_q;
    assign rvalid_o = FWFT ? ~empty_o : rvalid_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: one standard and one FWFT instance share stimulus
// and are checked each cycle against a queue-based model.
module tb_sync_fifo_flags;
    import sync_fifo_flags_pkg::*;

    localparam int D = DEF_DEPTH;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wdata = '0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;

    logic       s_wr_err, s_full, s_af, s_rd_err, s_empty, s_ae, s_rvalid;
    logic [7:0] s_rdata;
    logic [4:0] s_count;
    logic       f_wr_err, f_full, f_af, f_rd_err, f_empty, f_ae, f_rvalid;
    logic [7:0] f_rdata;
    logic [4:0] f_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic [7:0] last_std = '0;
    logic       exp_wr_err = 1'b0;
    logic       exp_rd_err = 1'b0;
    logic       exp_rvalid = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_flags #(.FWFT(1'b0)) u_std (
        .clk_i(clk), .rst_i(rst), .wdata_i(wdata), .wr_en_i(wr_en),
        .wr_error_o(s_wr_err), .full_o(s_full), .almost_full_o(s_af),
        .rdata_o(s_rdata), .rd_en_i(rd_en), .rd_error_o(s_rd_err),
        .empty_o(s_empty), .almost_empty_o(s_ae), .rvalid_o(s_rvalid),
        .count_o(s_count)
    );

    sync_fifo_flags #(.FWFT(1'b1)) u_fwft (
        .clk_i(clk), .rst_i(rst), .wdata_i(wdata), .wr_en_i(wr_en),
        .wr_error_o(f_wr_err), .full_o(f_full), .almost_full_o(f_af),
        .rdata_o(f_rdata), .rd_en_i(rd_en), .rd_error_o(f_rd_err),
        .empty_o(f_empty), .almost_empty_o(f_ae), .rvalid_o(f_rvalid),
        .count_o(f_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("std_count", 32'(s_count), 32'(n));
        chk("fwft_count", 32'(f_count), 32'(n));
        chk("std_empty", 32'(s_empty), 32'(n == 0));
        chk("fwft_empty", 32'(f_empty), 32'(n == 0));
        chk("std_full", 32'(s_full), 32'(n == D));
        chk("fwft_full", 32'(f_full), 32'(n == D));
        chk("std_af", 32'(s_af), 32'(n >= DEF_AF_THRESH));
        chk("fwft_af", 32'(f_af), 32'(n >= DEF_AF_THRESH));
        chk("std_ae", 32'(s_ae), 32'(n <= DEF_AE_THRESH));
        chk("fwft_ae", 32'(f_ae), 32'(n <= DEF_AE_THRESH));
        chk("std_wr_err", 32'(s_wr_err), 32'(exp_wr_err));
        chk("fwft_wr_err", 32'(f_wr_err), 32'(exp_wr_err));
        chk("std_rd_err", 32'(s_rd_err), 32'(exp_rd_err));
        chk("fwft_rd_err", 32'(f_rd_err), 32'(exp_rd_err));
        chk("std_rvalid", 32'(s_rvalid), 32'(exp_rvalid));
        chk("std_rdata", 32'(s_rdata), 32'(last_std));
        chk("fwft_rvalid", 32'(f_rvalid), 32'(n != 0));
        if (n != 0) begin
            chk("fwft_rdata", 32'(f_rdata), 32'(q[0]));
        end
    endtask

    // Drive one cycle of requests, advance the model across the edge, then check.
    task automatic step(input logic wr, input logic rd, input logic [7:0] d);
        int  cnt;
        logic rok, wok;
        wr_en = wr;
        rd_en = rd;
        wdata = d;
        cnt = q.size();
        rok = rd && (cnt > 0);
        wok = wr && ((cnt < D) || rok);
        exp_wr_err = wr && (cnt == D) && !rok;
        exp_rd_err = rd && (cnt == 0);
        exp_rvalid = rok;
        @(posedge clk);
        if (rok) last_std = q.pop_front();
        if (wok) q.push_back(d);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_all();
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all();

        // Fill 0x01..0x10, then one write too many
        for (int i = 1; i <= D; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b0, 8'h55);
        step(1'b0, 1'b0, 8'h00);

        // Drain in order, then one read too many
        for (int i = 0; i < D; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Three rounds of 10 in / 10 out across the pointer wrap
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'($urandom));
            for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00);
        end

        // Full with simultaneous read and write of 0xAA
        for (int i = 0; i < D; i++) step(1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b1, 8'hAA);
        for (int i = 0; i < D; i++) step(1'b0, 1'b1, 8'h00);
        chk("aa_last", 32'(last_std), 32'h0000_00AA);

        // Empty with simultaneous read and write
        step(1'b1, 1'b1, 8'h3C);
        step(1'b0, 1'b1, 8'h00);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end
        while (q.size() != 0) step(1'b0, 1'b1, 8'h00);

        // Reset asserted between edges with 7 entries stored
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'($urandom));
        #3;
        rst = 1'b1;
        #1;
        q.delete();
        last_std   = '0;
        exp_wr_err = 1'b0;
        exp_rd_err = 1'b0;
        exp_rvalid = 1'b0;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 8'h77);
        step(1'b0, 1'b1, 8'h00);
        chk("post_reset_first", 32'(last_std), 32'h0000_0077);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
